// File: rtl/hex_bcd_counter_if.sv
// Pushbutton/switch inputs and seven-segment/LED outputs
// of the SW/HEX demo counter.
interface hex_bcd_counter_if;
    logic [3:1] KEY;
    logic [9:0] SW;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [6:0] HEX4;
    logic [6:0] HEX5;
    logic [9:0] LEDR;

    modport master (
        output KEY, SW,
        input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR
    );

    modport slave (
        input  KEY, SW,
        output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR
    );
endinterface

// File: rtl/hex_bcd_counter.sv
// Six-digit BCD up/down counter with run/pause, load and
// direction keys; drives active-low seven-segment digits.
module hex_bcd_counter #(
    parameter int TICK_DIV = 50000000
) (
    input logic CLOCK_50,
    input logic Resetn,
    hex_bcd_counter_if.slave io
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    typedef enum logic {PAUSED, RUNNING} state_t;

    state_t state, state_nx;

    logic [3:1] s1, s2, s3;
    logic [3:1] press;
    logic load_p, run_p, dir_p;
    logic running, step;

    logic [PW-1:0] presc;
    logic dir_down;
    logic wrap_f;
    logic [5:0][3:0] dig;
    logic [5:0][3:0] dig_step;
    logic [5:0][3:0] dig_load;
    logic wrap;
    logic [5:0][6:0] hex;

    wire unused_sw = &{1'b0, io.SW[9:8]};

    function automatic logic [3:0] clamp9(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    // Keys are asynchronous: two-flop sync plus a history flop
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            s1 <= '1;
            s2 <= '1;
            s3 <= '1;
        end else begin
            s1 <= io.KEY;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign press  = s3 & ~s2;
    assign load_p = press[2];
    assign run_p  = press[1] & ~press[2];
    assign dir_p  = press[3];

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) state <= PAUSED;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (1'b1)
            load_p:  state_nx = PAUSED;
            run_p:   state_nx = (state == PAUSED) ? RUNNING : PAUSED;
            default: state_nx = state;
        endcase
    end

    always_comb begin
        running = (state == RUNNING);
        step    = running && (presc == LAST);
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            presc <= '0;
        end else if (load_p || (run_p && !running)) begin
            presc <= '0;
        end else if (running) begin
            presc <= step ? '0 : presc + PW'(1);
        end
    end

    // Ripple carry/borrow; carry out of digit 5 is the wrap
    always_comb begin
        logic c;
        dig_step = dig;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (c) begin
                if (dir_down) begin
                    if (dig[i] == 4'd0) begin
                        dig_step[i] = 4'd9;
                    end else begin
                        dig_step[i] = dig[i] - 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (dig[i] == 4'd9) begin
                        dig_step[i] = 4'd0;
                    end else begin
                        dig_step[i] = dig[i] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        wrap = c;
    end

    always_comb begin
        dig_load    = '0;
        dig_load[0] = clamp9(io.SW[3:0]);
        dig_load[1] = clamp9(io.SW[7:4]);
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            dig    <= '0;
            wrap_f <= 1'b0;
        end else if (load_p) begin
            dig <= dig_load;
        end else if (step) begin
            dig <= dig_step;
            if (wrap) wrap_f <= ~wrap_f;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn)    dir_down <= 1'b0;
        else if (dir_p) dir_down <= ~dir_down;
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            hex <= {6{7'b1000000}};
        end else begin
            for (int i = 0; i < 6; i++) hex[i] <= seg(dig[i]);
        end
    end

    assign io.HEX0 = hex[0];
    assign io.HEX1 = hex[1];
    assign io.HEX2 = hex[2];
    assign io.HEX3 = hex[3];
    assign io.HEX4 = hex[4];
    assign io.HEX5 = hex[5];
    assign io.LEDR = {wrap_f, 7'b0, dir_down, running};
endmodule
